rcosc_reset_seq: RTL and testbench

// - Power-on / lock-loss reset sequencer clocked from the 160 MHz on-chip RC oscillator global net.
// - Synchronises and filters the fabric PLL lock and an external reset button.
// - Releases STAGES active-low reset domains in order, with a fixed gap between them.
// - Sits directly downstream of the RC oscillator instance; its outputs feed every fabric reset tree.

---
 rtl/rcosc_reset_seq.sv | 166 ++++++++++++++++
 tb/tb_rcosc_reset_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcosc_reset_seq.sv
// rcosc_reset_seq: power-on / lock-loss reset sequencer on the RC oscillator clock.
// Synchronises PLL_LOCK and EXT_RSTN, qualifies the lock with a filter, holds all
// resets for a fixed time, then releases STAGES reset domains in order with a fixed gap.
// Optional build macro: RSTSEQ_WDOG_EN adds a WAIT_LOCK watchdog driving LOCK_TIMEOUT.
module rcosc_reset_seq #(
  parameter int SYNC_DEPTH  = 2,
  parameter int LOCK_FILT   = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 16,
  parameter int WDOG_CYCLES = 2**20
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              PLL_LOCK,
  input  logic              EXT_RSTN,
  output logic [STAGES-1:0] RSTN_OUT,
  output logic              READY,
  output logic [7:0]        LOCK_LOST_CNT,
  output logic [1:0]        STATE,
  output logic              LOCK_TIMEOUT
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int FILT_W  = $clog2(LOCK_FILT) + 1;
  localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int GAP_MAX = (STAGES - 1) * STAGE_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX) + 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX);

  logic [SYNC_DEPTH-1:0] r_lock_sync;
  logic [SYNC_DEPTH-1:0] r_ext_sync;
  logic                  w_lock_s;
  logic                  w_ext_s;
  logic                  w_abort;

  state_t                r_state;
  logic [FILT_W-1:0]     r_filt_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [STAGES-1:0]     r_rstn;
  logic                  r_ready;
  logic [7:0]            r_lost_cnt;

  assign w_lock_s = r_lock_sync[SYNC_DEPTH-1];
  assign w_ext_s  = r_ext_sync[SYNC_DEPTH-1];
  // Either input dropping (ext_s low means the button is pressed) restarts the sequence.
  assign w_abort  = !(w_lock_s && w_ext_s);

  // Input synchronisers; cleared to 0 so both inputs read as "reset asserted" after RESETN.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_lock_sync <= '0;
      r_ext_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_DEPTH-2:0], PLL_LOCK};
      r_ext_sync  <= {r_ext_sync[SYNC_DEPTH-2:0], EXT_RSTN};
    end
  end

  // Sequencer FSM with registered reset outputs, READY and the lock-loss counter.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rstn     <= '0;
      r_ready    <= 1'b0;
      r_lost_cnt <= '0;
    end else if (w_abort) begin
      r_state    <= ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rstn     <= '0;
      r_ready    <= 1'b0;
      // Only a loss of an already-qualified lock counts; a button press alone never does.
      if (r_state != ST_WAIT_LOCK && !w_lock_s && r_lost_cnt != 8'hFF)
        r_lost_cnt <= r_lost_cnt + 8'd1;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (r_filt_cnt == FILT_LAST) begin
            r_state    <= ST_HOLD;
            r_filt_cnt <= '0;
          end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RELEASE;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Bit i goes high when the gap counter reaches i*STAGE_GAP and then stays high.
          for (int i = 0; i < STAGES; i++) begin
            if (r_gap_cnt == GAP_W'(i * STAGE_GAP))
              r_rstn[i] <= 1'b1;
          end
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= ST_RUN;
            r_ready   <= 1'b1;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

`ifdef RSTSEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_lock_timeout;

  // Diagnostic watchdog: sticky flag once WAIT_LOCK lasts WDOG_CYCLES cycles.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wd_cnt       <= '0;
      r_lock_timeout <= 1'b0;
    end else if (r_state == ST_WAIT_LOCK) begin
      if (r_wd_cnt != WD_MAX)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt == WD_LAST)
        r_lock_timeout <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign LOCK_TIMEOUT = r_lock_timeout;
`else
  // No watchdog built in; the flag is a constant 0 whatever WDOG_CYCLES is.
  assign LOCK_TIMEOUT = 1'b0 & (WDOG_CYCLES > 0);
`endif

  assign RSTN_OUT      = r_rstn;
  assign READY         = r_ready;
  assign LOCK_LOST_CNT = r_lost_cnt;
  assign STATE         = r_state;

endmodule

// File: tb/tb_rcosc_reset_seq.sv
// Self-checking bench for rcosc_reset_seq with a streak-length reference model.
module tb_rcosc_reset_seq;

  localparam int SD  = 2;
  localparam int LF  = 4;
  localparam int HC  = 16;
  localparam int ST  = 3;
  localparam int GAP = 4;
  localparam int WD  = 64;
  // Streak lengths (consecutive qualified-good synced samples) at which things happen.
  localparam int T_HOLD = LF;
  localparam int T_REL  = LF + HC;
  localparam int T_RUN  = LF + HC + 1 + (ST - 1) * GAP;
`ifdef RSTSEQ_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          PLL_LOCK = 1'b0;
  logic          EXT_RSTN = 1'b0;
  logic [ST-1:0] RSTN_OUT;
  logic          READY;
  logic [7:0]    LOCK_LOST_CNT;
  logic [1:0]    STATE;
  logic          LOCK_TIMEOUT;

  int n_checks = 0;
  int n_fails  = 0;

  rcosc_reset_seq #(
    .SYNC_DEPTH (SD),
    .LOCK_FILT  (LF),
    .HOLD_CYCLES(HC),
    .STAGES     (ST),
    .STAGE_GAP  (GAP),
    .WDOG_CYCLES(WD)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .PLL_LOCK     (PLL_LOCK),
    .EXT_RSTN     (EXT_RSTN),
    .RSTN_OUT     (RSTN_OUT),
    .READY        (READY),
    .LOCK_LOST_CNT(LOCK_LOST_CNT),
    .STATE        (STATE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  wire [14:0] w_obs = {STATE, READY, RSTN_OUT, LOCK_LOST_CNT, LOCK_TIMEOUT};

  // Reference model: everything follows from how long the synced inputs have been good.
  bit m_lock_d [SD];
  bit m_ext_d  [SD];
  int m_n;
  int m_lost;
  int m_wd;
  bit m_to;

  always @(posedge CLK or negedge RESETN) begin : mdl
    bit ls;
    bit es;
    if (!RESETN) begin
      for (int i = 0; i < SD; i++) begin
        m_lock_d[i] = 1'b0;
        m_ext_d[i]  = 1'b0;
      end
      m_n = 0; m_lost = 0; m_wd = 0; m_to = 1'b0;
    end else begin
      ls = m_lock_d[SD-1];
      es = m_ext_d[SD-1];
      if (m_n < T_HOLD) begin
        if (m_wd < WD) m_wd++;
      end else begin
        m_wd = 0;
      end
      if (WD_ON && m_wd >= WD) m_to = 1'b1;
      if (ls && es) begin
        if (m_n < 100000) m_n++;
      end else begin
        if (!ls && m_n >= T_HOLD && m_lost < 255) m_lost++;
        m_n = 0;
      end
      for (int i = SD - 1; i > 0; i--) begin
        m_lock_d[i] = m_lock_d[i-1];
        m_ext_d[i]  = m_ext_d[i-1];
      end
      m_lock_d[0] = PLL_LOCK;
      m_ext_d[0]  = EXT_RSTN;
    end
  end

  function automatic logic [1:0] exp_state();
    if (m_n < T_HOLD)     return 2'd0;
    else if (m_n < T_REL) return 2'd1;
    else if (m_n < T_RUN) return 2'd2;
    else                  return 2'd3;
  endfunction

  function automatic logic [ST-1:0] exp_rstn();
    logic [ST-1:0] r;
    for (int i = 0; i < ST; i++) r[i] = (m_n >= T_REL + 1 + i * GAP);
    return r;
  endfunction

  function automatic logic [14:0] exp_vec();
    return {exp_state(), (m_n >= T_RUN), exp_rstn(), 8'(m_lost), m_to};
  endfunction

  task automatic do_reset(input bit lock, input bit ext);
    @(negedge CLK);
    RESETN = 1'b0; PLL_LOCK = lock; EXT_RSTN = ext;
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++; if (RSTN_OUT !== 3'b000) begin n_fails++; $display("FAIL reset_rstn got %b expected 000", RSTN_OUT); end
    n_checks++; if (READY !== 1'b0) begin n_fails++; $display("FAIL reset_ready got %b expected 0", READY); end
    n_checks++; if (LOCK_LOST_CNT !== 8'd0) begin n_fails++; $display("FAIL reset_lost got %0d expected 0", LOCK_LOST_CNT); end
    n_checks++; if (STATE !== 2'd0) begin n_fails++; $display("FAIL reset_state got %0d expected 0", STATE); end
    n_checks++; if (LOCK_TIMEOUT !== 1'b0) begin n_fails++; $display("FAIL reset_timeout got %b expected 0", LOCK_TIMEOUT); end
  endtask

  task automatic test_nominal();
    int e_hold, e_b0, e_b1, e_b2, e_rdy;
    e_hold = -1; e_b0 = -1; e_b1 = -1; e_b2 = -1; e_rdy = -1;
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL nominal_outputs edge %0d got %h expected %h", e, w_obs, exp_vec()); end
      if (e_hold < 0 && STATE == 2'd1) e_hold = e;
      if (e_b0 < 0 && RSTN_OUT == 3'b001) e_b0 = e;
      if (e_b1 < 0 && RSTN_OUT == 3'b011) e_b1 = e;
      if (e_b2 < 0 && RSTN_OUT == 3'b111) e_b2 = e;
      if (e_rdy < 0 && READY == 1'b1) e_rdy = e;
    end
    n_checks++; if (e_hold !== SD + LF) begin n_fails++; $display("FAIL nominal_hold_edge got %0d expected %0d", e_hold, SD + LF); end
    n_checks++; if (e_b0 !== SD + LF + HC + 1) begin n_fails++; $display("FAIL nominal_rstn0_edge got %0d expected %0d", e_b0, SD + LF + HC + 1); end
    n_checks++; if (e_b1 !== SD + LF + HC + 1 + GAP) begin n_fails++; $display("FAIL nominal_rstn1_edge got %0d expected %0d", e_b1, SD + LF + HC + 1 + GAP); end
    n_checks++; if (e_b2 !== SD + LF + HC + 1 + 2 * GAP) begin n_fails++; $display("FAIL nominal_rstn2_edge got %0d expected %0d", e_b2, SD + LF + HC + 1 + 2 * GAP); end
    n_checks++; if (e_rdy !== SD + LF + HC + 1 + 2 * GAP) begin n_fails++; $display("FAIL nominal_ready_edge got %0d expected %0d", e_rdy, SD + LF + HC + 1 + 2 * GAP); end
    n_checks++; if (STATE !== 2'd3) begin n_fails++; $display("FAIL nominal_run_state got %0d expected 3", STATE); end
  endtask

  task automatic test_lock_glitch();
    int e_hold;
    e_hold = -1;
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL glitch_outputs edge %0d got %h expected %h", e, w_obs, exp_vec()); end
      if (e_hold < 0 && STATE == 2'd1) e_hold = e;
      if (e == 3) PLL_LOCK = 1'b0;
      if (e == 4) PLL_LOCK = 1'b1;
    end
    n_checks++; if (e_hold !== 4 + SD + LF) begin n_fails++; $display("FAIL glitch_hold_edge got %0d expected %0d", e_hold, 4 + SD + LF); end
    n_checks++; if (LOCK_LOST_CNT !== 8'd0) begin n_fails++; $display("FAIL glitch_lost got %0d expected 0", LOCK_LOST_CNT); end
  endtask

  task automatic test_lock_loss_run();
    int e_drop;
    logic rdy_at_drop;
    e_drop = -1; rdy_at_drop = 1'bx;
    do_reset(1'b1, 1'b1);
    repeat (35) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL loss_pre_outputs got %h expected %h", w_obs, exp_vec()); end
    end
    PLL_LOCK = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL loss_outputs k %0d got %h expected %h", k, w_obs, exp_vec()); end
      if (e_drop < 0 && RSTN_OUT == 3'b000) begin e_drop = k; rdy_at_drop = READY; end
    end
    n_checks++; if (e_drop !== SD + 1) begin n_fails++; $display("FAIL loss_drop_edge got %0d expected %0d", e_drop, SD + 1); end
    n_checks++; if (rdy_at_drop !== 1'b0) begin n_fails++; $display("FAIL loss_ready got %b expected 0", rdy_at_drop); end
    n_checks++; if (LOCK_LOST_CNT !== 8'd1) begin n_fails++; $display("FAIL loss_count got %0d expected 1", LOCK_LOST_CNT); end
    PLL_LOCK = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL relock_outputs got %h expected %h", w_obs, exp_vec()); end
    end
    n_checks++; if (READY !== 1'b1) begin n_fails++; $display("FAIL relock_ready got %b expected 1", READY); end
  endtask

  task automatic test_both_fall();
    PLL_LOCK = 1'b0; EXT_RSTN = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL both_outputs got %h expected %h", w_obs, exp_vec()); end
    end
    n_checks++; if (LOCK_LOST_CNT !== 8'd2) begin n_fails++; $display("FAIL both_count got %0d expected 2", LOCK_LOST_CNT); end
    PLL_LOCK = 1'b1; EXT_RSTN = 1'b1;
  endtask

  task automatic test_ext_pulse();
    bit found;
    int lost_before;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL ext_pre_outputs got %h expected %h", w_obs, exp_vec()); end
      if (RSTN_OUT == 3'b001) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fails++; $display("FAIL ext_reach_release got timeout expected RSTN_OUT=001"); end
    lost_before = m_lost;
    EXT_RSTN = 1'b0;
    for (int k = 1; k <= SD + 1; k++) begin
      @(negedge CLK);
      EXT_RSTN = 1'b1;
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL ext_outputs k %0d got %h expected %h", k, w_obs, exp_vec()); end
    end
    n_checks++; if (RSTN_OUT !== 3'b000) begin n_fails++; $display("FAIL ext_rstn got %b expected 000", RSTN_OUT); end
    n_checks++; if (STATE !== 2'd0) begin n_fails++; $display("FAIL ext_state got %0d expected 0", STATE); end
    n_checks++; if (int'(LOCK_LOST_CNT) !== lost_before) begin n_fails++; $display("FAIL ext_lost got %0d expected %0d", LOCK_LOST_CNT, lost_before); end
  endtask

  task automatic test_watchdog();
    do_reset(1'b0, 1'b1);
    for (int e = 1; e <= 100; e++) begin
      @(negedge CLK);
      n_checks++;
      if (LOCK_TIMEOUT !== (WD_ON && e >= WD)) begin n_fails++; $display("FAIL wdog_flag edge %0d got %b expected %b", e, LOCK_TIMEOUT, (WD_ON && e >= WD)); end
    end
    PLL_LOCK = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL wdog_lock_outputs got %h expected %h", w_obs, exp_vec()); end
    end
    n_checks++; if (LOCK_TIMEOUT !== WD_ON) begin n_fails++; $display("FAIL wdog_sticky got %b expected %b", LOCK_TIMEOUT, WD_ON); end
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1);
    repeat (3000) begin
      @(negedge CLK);
      n_checks++;
      if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL random_outputs got %h expected %h", w_obs, exp_vec()); end
      if (!RESETN) RESETN = 1'b1;
      else if ($urandom_range(0, 999) < 2) RESETN = 1'b0;
      if ($urandom_range(0, 99) < 2) PLL_LOCK = ~PLL_LOCK;
      if ($urandom_range(0, 99) < 1) EXT_RSTN = ~EXT_RSTN;
    end
    RESETN = 1'b1;
  endtask

  task automatic test_saturation();
    int h;
    int l;
    do_reset(1'b0, 1'b1);
    for (int it = 0; it < 300; it++) begin
      h = $urandom_range(LF + 1, 30);
      l = $urandom_range(1, 4);
      PLL_LOCK = 1'b1;
      repeat (h) begin
        @(negedge CLK);
        n_checks++;
        if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL sat_outputs_hi got %h expected %h", w_obs, exp_vec()); end
      end
      PLL_LOCK = 1'b0;
      repeat (l) begin
        @(negedge CLK);
        n_checks++;
        if (w_obs !== exp_vec()) begin n_fails++; $display("FAIL sat_outputs_lo got %h expected %h", w_obs, exp_vec()); end
      end
    end
    repeat (4) @(negedge CLK);
    n_checks++; if (LOCK_LOST_CNT !== 8'd255) begin n_fails++; $display("FAIL sat_count got %0d expected 255", LOCK_LOST_CNT); end
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    n_checks++; if (LOCK_LOST_CNT !== 8'd0) begin n_fails++; $display("FAIL sat_async_clear got %0d expected 0", LOCK_LOST_CNT); end
    n_checks++; if (RSTN_OUT !== 3'b000) begin n_fails++; $display("FAIL sat_async_rstn got %b expected 000", RSTN_OUT); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got no finish expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_lock_loss_run();
    test_both_fall();
    test_ext_pulse();
    test_watchdog();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
